// File: rtl/dcache_coh_ctrl.sv
// rtl/dcache_coh_ctrl.sv - MSI snoopy data-cache controller, one instance per core
// Direct-mapped, one word per line. Serves CPU loads/stores, requests the bus
// on misses/upgrades, writes back dirty victims, and answers bus snoops.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cpu_re/cpu_we/cpu_addr/cpu_wdata  CPU request (held while cpu_stall)
//   cpu_rdata/cpu_stall               load data / hold request
//   read_miss/write_miss/invalidate   bus requests, address on bico
//   grant, fill_valid/fill_data       bus grant and fill word
//   search/snoop_addr/inv_from_other  snoop probe and remote invalidate
//   search_found/snoop_data/block_state  snooped line result
//   wb_req/wb_addr/wb_data/wb_ack     dirty-victim writeback handshake
// Optional feature macro: COH_PERF_CNT_EN adds hit_cnt/miss_cnt/upg_cnt.
module dcache_coh_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              read_miss,
    output logic              write_miss,
    output logic              invalidate,
    output logic [ADDR_W-1:0] bico,
    input  logic              grant,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              search,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              search_found,
    output logic [DATA_W-1:0] snoop_data,
    output logic [1:0]        block_state,
    input  logic              inv_from_other,
    output logic              wb_req,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ack
`ifdef COH_PERF_CNT_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       upg_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;

    typedef enum logic [2:0] {IDLE, WB, REQ, FILL, UPG} fsm_t;

    fsm_t              fsm_q;
    logic [1:0]        st_q   [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic              op_we_q;     // pending request is a store
    logic [ADDR_W-1:0] req_addr_q;  // address of the pending request

    logic [INDEX_W-1:0] cidx, ridx, sidx;
    logic [TAG_W-1:0]   ctag, rtag, stag;
    assign cidx = cpu_addr[INDEX_W-1:0];
    assign ctag = cpu_addr[ADDR_W-1:INDEX_W];
    assign ridx = req_addr_q[INDEX_W-1:0];
    assign rtag = req_addr_q[ADDR_W-1:INDEX_W];
    assign sidx = snoop_addr[INDEX_W-1:0];
    assign stag = snoop_addr[ADDR_W-1:INDEX_W];

    logic c_valid, is_idle, cpu_req, read_hit, wr_hit_m, wr_hit_s, miss;
    assign c_valid  = (st_q[cidx] != ST_I) && (tag_q[cidx] == ctag);
    assign is_idle  = (fsm_q == IDLE);
    assign cpu_req  = cpu_re || cpu_we;
    assign read_hit = is_idle && !cpu_we && cpu_re && c_valid;
    assign wr_hit_m = is_idle && cpu_we && c_valid && (st_q[cidx] == ST_M);
    assign wr_hit_s = is_idle && cpu_we && c_valid && (st_q[cidx] == ST_S);
    assign miss     = is_idle && cpu_req && !c_valid;

    logic s_match, inv_hit, upg_lost;
    assign s_match = (st_q[sidx] != ST_I) && (tag_q[sidx] == stag);
    assign inv_hit = inv_from_other && s_match;
    // An upgrade loses its S copy when a remote invalidate hits it now or
    // already did; the store then has to be re-requested as a write miss.
    assign upg_lost = (fsm_q == UPG) &&
                      ((inv_hit && (sidx == ridx)) ||
                       !((st_q[ridx] == ST_S) && (tag_q[ridx] == rtag)));

    assign cpu_stall    = !is_idle || (cpu_req && !(read_hit || wr_hit_m));
    assign cpu_rdata    = read_hit ? data_q[cidx] : '0;
    assign read_miss    = (fsm_q == REQ) && !op_we_q;
    assign write_miss   = (fsm_q == REQ) && op_we_q;
    assign invalidate   = (fsm_q == UPG);
    assign bico         = ((fsm_q == REQ) || (fsm_q == UPG)) ? req_addr_q : '0;
    assign wb_req       = (fsm_q == WB);
    assign wb_addr      = wb_req ? {tag_q[ridx], ridx} : '0;
    assign wb_data      = wb_req ? data_q[ridx] : '0;
    assign search_found = search && s_match;
    assign block_state  = s_match ? st_q[sidx] : ST_I;
    assign snoop_data   = data_q[sidx];

    // Local line write; applied after the snoop update so it wins on a
    // same-line collision (fill completion, write hit on M).
    logic               lw_en;
    logic [INDEX_W-1:0] lw_idx;
    logic [TAG_W-1:0]   lw_tag;
    logic [DATA_W-1:0]  lw_data;
    logic [1:0]         lw_st;
    always_comb begin
        lw_en   = 1'b0;
        lw_idx  = cidx;
        lw_tag  = ctag;
        lw_data = cpu_wdata;
        lw_st   = ST_M;
        if (wr_hit_m) begin
            lw_en = 1'b1;
        end else if ((fsm_q == UPG) && grant && !upg_lost) begin
            lw_en  = 1'b1;
            lw_idx = ridx;
            lw_tag = rtag;
        end else if ((fsm_q == FILL) && fill_valid) begin
            lw_en   = 1'b1;
            lw_idx  = ridx;
            lw_tag  = rtag;
            lw_data = op_we_q ? cpu_wdata : fill_data;
            lw_st   = op_we_q ? ST_M : ST_S;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                st_q[i]   <= ST_I;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            fsm_q      <= IDLE;
            op_we_q    <= 1'b0;
            req_addr_q <= '0;
        end else begin
            if (inv_hit)
                st_q[sidx] <= ST_I;
            else if (search && s_match && (st_q[sidx] == ST_M))
                st_q[sidx] <= ST_S;
            if ((fsm_q == WB) && wb_ack)
                st_q[ridx] <= ST_I;
            if (lw_en) begin
                st_q[lw_idx]   <= lw_st;
                tag_q[lw_idx]  <= lw_tag;
                data_q[lw_idx] <= lw_data;
            end
            case (fsm_q)
                IDLE: begin
                    if (miss) begin
                        op_we_q    <= cpu_we;
                        req_addr_q <= cpu_addr;
                        fsm_q      <= (st_q[cidx] == ST_M) ? WB : REQ;
                    end else if (wr_hit_s) begin
                        op_we_q    <= 1'b1;
                        req_addr_q <= cpu_addr;
                        fsm_q      <= UPG;
                    end
                end
                WB:      if (wb_ack) fsm_q <= REQ;
                REQ:     if (grant) fsm_q <= FILL;
                FILL:    if (fill_valid) fsm_q <= IDLE;
                UPG: begin
                    if (upg_lost)   fsm_q <= REQ;
                    else if (grant) fsm_q <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

`ifdef COH_PERF_CNT_EN
    logic hit_ev, miss_ev, upg_ev;
    assign hit_ev  = read_hit || wr_hit_m;
    assign miss_ev = (miss && (st_q[cidx] != ST_M)) || ((fsm_q == WB) && wb_ack) || upg_lost;
    assign upg_ev  = wr_hit_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            upg_cnt  <= '0;
        end else begin
            if (hit_ev && (hit_cnt != 16'hFFFF))   hit_cnt  <= hit_cnt + 16'd1;
            if (miss_ev && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
            if (upg_ev && (upg_cnt != 16'hFFFF))   upg_cnt  <= upg_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_coh_ctrl.sv
// tb/tb_dcache_coh_ctrl.sv - self-checking bench for dcache_coh_ctrl
module tb_dcache_coh_ctrl;
    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_re, cpu_we, grant, fill_valid, search, inv_from_other, wb_ack;
    logic [12:0] cpu_addr, snoop_addr, bico, wb_addr;
    logic [15:0] cpu_wdata, fill_data, cpu_rdata, snoop_data, wb_data;
    logic        cpu_stall, read_miss, write_miss, invalidate, search_found, wb_req;
    logic [1:0]  block_state;
`ifdef COH_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt, upg_cnt;
`endif

    always #5 clk = ~clk;

    dcache_coh_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate), .bico(bico),
        .grant(grant), .fill_valid(fill_valid), .fill_data(fill_data),
        .search(search), .snoop_addr(snoop_addr), .search_found(search_found),
        .snoop_data(snoop_data), .block_state(block_state), .inv_from_other(inv_from_other),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack)
`ifdef COH_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .upg_cnt(upg_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Transaction-level reference: per-line MSI state and a global memory image.
    logic [1:0]  m_st   [NL];
    logic [9:0]  m_tag  [NL];
    logic [15:0] m_data [NL];
    logic [15:0] mem    [8192];

    typedef struct {
        logic [12:0] addr; logic srch; logic exp_found; logic [1:0] exp_state; logic [15:0] exp_data;
    } snoop_vec_t;
    typedef struct {
        logic re; logic we; logic [12:0] addr; logic exp_stall; logic [15:0] exp_rdata;
    } cpu_vec_t;
    snoop_vec_t svec [5];
    cpu_vec_t   cvec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        grant = 0; fill_valid = 0; fill_data = '0;
        search = 0; snoop_addr = '0; inv_from_other = 0; wb_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_st[i] = 2'b00; m_tag[i] = '0; m_data[i] = '0;
        end
    endtask

    // Request already driven in the IDLE cycle: REQ, grant, FILL with fd.
    task automatic fill_miss(input logic [15:0] fd);
        tick();
        grant = 1; tick(); grant = 0;
        fill_valid = 1; fill_data = fd; tick(); fill_valid = 0;
    endtask

    // One CPU load/store with the bench acting as bus, arbiter and memory.
    task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [15:0] wd);
        int idx, cyc, wait_n, fdly, saw_wb, saw_upg, saw_req;
        logic [9:0] tg;
        logic hit, exp_wb, exp_upg, done, fill_pend;
        logic [12:0] wb_a;
        logic [15:0] wb_d, exp_rd;
        idx = int'(addr[2:0]); tg = addr[12:3];
        hit = (m_st[idx] != 2'b00) && (m_tag[idx] == tg);
        exp_wb = !hit && (m_st[idx] == 2'b10);
        exp_upg = we && hit && (m_st[idx] == 2'b01);
        wb_a = {m_tag[idx], addr[2:0]}; wb_d = m_data[idx];
        exp_rd = hit ? m_data[idx] : mem[addr];
        cyc = 0; saw_wb = 0; saw_upg = 0; saw_req = 0; done = 0; fill_pend = 0; fdly = 0;
        wait_n = $urandom_range(0, 2);
        cpu_we = we; cpu_re = !we; cpu_addr = addr; cpu_wdata = wd;
        while (!done && cyc < 50) begin
            grant = 0; wb_ack = 0; fill_valid = 0;
            #1;
            if (!cpu_stall) begin
                if (!we) chk("op_load_data", cpu_rdata, exp_rd);
                done = 1;
            end else begin
                chk("op_req_onehot", $countones({read_miss, write_miss, invalidate, wb_req}) <= 1, 1);
                if (fill_pend) begin
                    if (fdly == 0) begin
                        fill_valid = 1; fill_data = mem[addr]; fill_pend = 0;
                    end else fdly--;
                end else if (wb_req) begin
                    if (saw_wb == 0) begin
                        chk("op_wb_addr", wb_addr, wb_a);
                        chk("op_wb_data", wb_data, wb_d);
                    end
                    saw_wb++;
                    if (wait_n == 0) begin wb_ack = 1; wait_n = $urandom_range(0, 2); end
                    else wait_n--;
                end else if (read_miss || write_miss) begin
                    if (saw_req == 0) begin
                        chk("op_miss_kind", {write_miss, read_miss}, we ? 2'b10 : 2'b01);
                        chk("op_miss_bico", bico, addr);
                    end
                    saw_req++;
                    if (wait_n == 0) begin
                        grant = 1; fill_pend = 1;
                        fdly = $urandom_range(0, 2); wait_n = $urandom_range(0, 2);
                    end else wait_n--;
                end else if (invalidate) begin
                    if (saw_upg == 0) chk("op_upg_bico", bico, addr);
                    saw_upg++;
                    if (wait_n == 0) begin grant = 1; wait_n = $urandom_range(0, 2); end
                    else wait_n--;
                end
            end
            if (!done) begin
                @(posedge clk); #1; cyc++;
            end
        end
        chk("op_completed", done, 1);
        chk("op_wb_seen", saw_wb > 0, exp_wb);
        chk("op_upg_seen", saw_upg > 0, exp_upg);
        chk("op_miss_seen", saw_req > 0, !hit);
        tick();  // store commits on this edge
        idle_inputs();
        if (exp_wb) mem[wb_a] = wb_d;
        if (!hit || we) begin
            m_tag[idx] = tg;
            m_data[idx] = we ? wd : mem[addr];
            m_st[idx] = we ? 2'b10 : 2'b01;
        end
    endtask

    task automatic snoop_op(input logic inv, input logic [12:0] a);
        int idx;
        logic m;
        idx = int'(a[2:0]);
        m = (m_st[idx] != 2'b00) && (m_tag[idx] == a[12:3]);
        search = !inv; inv_from_other = inv; snoop_addr = a;
        #1;
        if (!inv) chk("rs_found", search_found, m);
        chk("rs_state", block_state, m ? m_st[idx] : 2'b00);
        if (m) chk("rs_data", snoop_data, m_data[idx]);
        tick();
        idle_inputs();
        if (m) begin
            if (inv) begin
                m_st[idx] = 2'b00;
                mem[a] = 16'($urandom);  // the remote writer now owns a new value
            end else if (m_st[idx] == 2'b10) begin
                m_st[idx] = 2'b01;
                mem[a] = m_data[idx];
            end
        end
    endtask

    initial begin
        logic [12:0] ra;
        int r;
        svec[0] = '{13'h010, 1, 1, 2'b10, 16'h1111};
        svec[1] = '{13'h010, 0, 0, 2'b10, 16'h1111};
        svec[2] = '{13'h02A, 1, 1, 2'b01, 16'h2A2A};
        svec[3] = '{13'h012, 1, 0, 2'b00, 16'h0000};
        svec[4] = '{13'h049, 1, 0, 2'b00, 16'h0000};
        cvec[0] = '{1, 0, 13'h010, 0, 16'h1111};
        cvec[1] = '{1, 0, 13'h02A, 0, 16'h2A2A};
        cvec[2] = '{1, 0, 13'h049, 1, 16'h0000};
        cvec[3] = '{0, 1, 13'h02A, 1, 16'h0000};
        cvec[4] = '{1, 0, 13'h050, 1, 16'h0000};
        cvec[5] = '{0, 0, 13'h010, 0, 16'h0000};
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_reqs", {read_miss, write_miss, invalidate, wb_req}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        rst_n = 1;
        tick();

        // Cold load 0x0041: three edges from request to unstall.
        cpu_re = 1; cpu_addr = 13'h041; #1;
        chk("cold_stall_idle", cpu_stall, 1);
        chk("cold_no_req_yet", read_miss, 0);
        tick();
        chk("cold_read_miss", read_miss, 1);
        chk("cold_bico", bico, 13'h041);
        grant = 1; tick(); grant = 0;
        chk("cold_fill_wait", {cpu_stall, read_miss}, 2'b10);
        fill_valid = 1; fill_data = 16'hBEEF; tick(); fill_valid = 0;
        chk("cold_unstall", cpu_stall, 0);
        chk("cold_rdata", cpu_rdata, 16'hBEEF);
        tick();
        chk("cold_rehit", {cpu_stall, cpu_rdata}, {1'b0, 16'hBEEF});
        idle_inputs();

        // Store on S: upgrade until grant.
        cpu_we = 1; cpu_addr = 13'h041; cpu_wdata = 16'h1234; #1;
        chk("upg_stall", cpu_stall, 1);
        tick();
        chk("upg_inv", {invalidate, bico}, {1'b1, 13'h041});
        tick();
        chk("upg_inv_held", invalidate, 1);
        grant = 1; tick(); grant = 0;
        chk("upg_done", {cpu_stall, invalidate}, 2'b00);
        tick();
        idle_inputs();
        cpu_re = 1; cpu_addr = 13'h041; #1;
        chk("upg_load", cpu_rdata, 16'h1234);
        snoop_addr = 13'h041; #1;
        chk("upg_state_m", block_state, 2'b10);
        idle_inputs();
        tick();

        // Store 0x0049 evicts dirty 0x0041.
        cpu_we = 1; cpu_addr = 13'h049; cpu_wdata = 16'h5678; #1;
        chk("wb_stall", cpu_stall, 1);
        tick();
        chk("wb_req", {wb_req, write_miss}, 2'b10);
        chk("wb_addr", wb_addr, 13'h041);
        chk("wb_data", wb_data, 16'h1234);
        wb_ack = 1; tick(); wb_ack = 0;
        chk("wb_then_wmiss", {wb_req, write_miss, bico}, {2'b01, 13'h049});
        grant = 1; tick(); grant = 0;
        fill_valid = 1; fill_data = 16'hAAAA; tick(); fill_valid = 0;
        chk("wmiss_unstall", cpu_stall, 0);
        tick();
        idle_inputs();
        cpu_re = 1; cpu_addr = 13'h049; #1;
        chk("wmiss_data", cpu_rdata, 16'h5678);
        idle_inputs();
        tick();

        // Snoop search on M, then remote invalidate.
        search = 1; snoop_addr = 13'h049; #1;
        chk("srch_found", search_found, 1);
        chk("srch_data", snoop_data, 16'h5678);
        chk("srch_state_m", block_state, 2'b10);
        tick(); search = 0; #1;
        chk("srch_state_s", block_state, 2'b01);
        inv_from_other = 1; tick(); inv_from_other = 0; #1;
        chk("inv_state_i", block_state, 2'b00);
        idle_inputs();

        // Upgrade on 0x0010 lost to a remote invalidate.
        cpu_re = 1; cpu_addr = 13'h010; fill_miss(16'h0F0F);
        idle_inputs();
        cpu_we = 1; cpu_addr = 13'h010; cpu_wdata = 16'h9ABC;
        tick();
        chk("col_upg", invalidate, 1);
        inv_from_other = 1; snoop_addr = 13'h010; tick(); inv_from_other = 0;
        chk("col_to_wmiss", {invalidate, write_miss}, 2'b01);
        chk("col_bico", bico, 13'h010);
        grant = 1; tick(); grant = 0;
        fill_valid = 1; fill_data = 16'h5555; tick(); fill_valid = 0;
        chk("col_unstall", cpu_stall, 0);
        tick();
        idle_inputs();
        snoop_addr = 13'h010; #1;
        chk("col_final_m", {block_state, snoop_data}, {2'b10, 16'h9ABC});
        idle_inputs();

        // Fill completing with a remote invalidate of the old copy: fill wins.
        cpu_re = 1; cpu_addr = 13'h012; fill_miss(16'h1212);
        idle_inputs();
        cpu_re = 1; cpu_addr = 13'h02A;
        tick();
        grant = 1; tick(); grant = 0;
        fill_valid = 1; fill_data = 16'h2A2A; inv_from_other = 1; snoop_addr = 13'h012;
        tick();
        idle_inputs();
        snoop_addr = 13'h02A; #1;
        chk("fillwin_state", block_state, 2'b01);

        // Remote invalidate during own write hit on M has no effect.
        cpu_we = 1; cpu_addr = 13'h010; cpu_wdata = 16'h1111;
        inv_from_other = 1; snoop_addr = 13'h010; #1;
        chk("excl_no_stall", cpu_stall, 0);
        tick();
        idle_inputs();
        snoop_addr = 13'h010; #1;
        chk("excl_kept_m", {block_state, snoop_data}, {2'b10, 16'h1111});

        // Stray grant and fill while idle are ignored.
        grant = 1; fill_valid = 1; fill_data = 16'hFFFF;
        tick();
        idle_inputs(); snoop_addr = 13'h010; #1;
        chk("stray_quiet", {cpu_stall, read_miss, write_miss}, 3'b000);
        chk("stray_line", snoop_data, 16'h1111);
        tick();

        // Table: combinational snoop probes, all in one cycle.
        for (int i = 0; i < 5; i++) begin
            search = svec[i].srch; snoop_addr = svec[i].addr; #1;
            chk("tbl_snoop_found", search_found, svec[i].exp_found);
            chk("tbl_snoop_state", block_state, svec[i].exp_state);
            if (svec[i].exp_state != 2'b00) chk("tbl_snoop_data", snoop_data, svec[i].exp_data);
        end
        idle_inputs();
        tick();
        // Table: combinational CPU hit/miss decisions, all in one cycle.
        for (int i = 0; i < 6; i++) begin
            cpu_re = cvec[i].re; cpu_we = cvec[i].we; cpu_addr = cvec[i].addr; cpu_wdata = 16'h7777; #1;
            chk("tbl_cpu_stall", cpu_stall, cvec[i].exp_stall);
            if (cvec[i].re && !cvec[i].exp_stall) chk("tbl_cpu_rdata", cpu_rdata, cvec[i].exp_rdata);
        end
        idle_inputs();
        tick();

        // Reset during FILL.
        cpu_re = 1; cpu_addr = 13'h033;
        tick();
        grant = 1; tick(); grant = 0;
        rst_n = 0; idle_inputs(); #1;
        chk("rstfill_reqs", {read_miss, write_miss, invalidate, wb_req, cpu_stall, search_found}, 0);
        chk("rstfill_buses", {bico, wb_addr, wb_data, cpu_rdata, snoop_data, block_state}, 0);
        tick();
        rst_n = 1;
        snoop_addr = 13'h010; #1;
        chk("rstfill_line10_i", block_state, 2'b00);
        snoop_addr = 13'h02A; #1;
        chk("rstfill_line2a_i", block_state, 2'b00);
        cpu_re = 1; cpu_addr = 13'h010; #1;
        chk("rstfill_miss", cpu_stall, 1);
        tick();
        chk("rstfill_read_miss", read_miss, 1);
        rst_n = 0; idle_inputs();
        tick();
        rst_n = 1;
        model_reset();
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            ra = {8'h00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            r = $urandom_range(0, 9);
            if (r <= 3)      cpu_op(1'b0, ra, 16'h0);
            else if (r <= 6) cpu_op(1'b1, ra, 16'($urandom));
            else if (r <= 8) snoop_op(1'b0, ra);
            else             snoop_op(1'b1, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_coh_ctrl.md
Name: dcache_coh_ctrl

Overview:
- Per-CPU snoopy data-cache controller with MSI states; one instance per core, sitting directly upstream of the two-CPU coherence bus arbiter.
- Serves CPU loads and stores from a direct-mapped, one-word-per-line cache.
- Raises read_miss, write_miss and invalidate requests toward the bus, then waits for grant and fill data.
- Answers bus snoops (search, remote invalidate) and exports the snooped line's state and data.

Parameters:
ADDR_W, 13, full word address width
DATA_W, 16, data word width
INDEX_W, 3, line index bits (2**INDEX_W lines); tag = ADDR_W-INDEX_W bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cpu_re  in  1  load request (level, held while stalled)
cpu_we  in  1  store request (level, held while stalled; wins over cpu_re)
cpu_addr  in  ADDR_W  load/store address
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid when cpu_re && !cpu_stall
cpu_stall  out  1  CPU must hold request
read_miss  out  1  bus read-miss request
write_miss  out  1  bus write-miss request
invalidate  out  1  bus upgrade (S->M) request
bico  out  ADDR_W  request address to bus
grant  in  1  bus grant for this core
fill_valid  in  1  one-cycle pulse, fill_data valid
fill_data  in  DATA_W  fill word (from dmem or other core)
search  in  1  bus snoop probe
snoop_addr  in  ADDR_W  snoop address
search_found  out  1  snoop hit (valid line, tag match)
snoop_data  out  DATA_W  data of snooped line
block_state  out  2  MSI state of snooped line: M=2'b10, S=2'b01, I=2'b00
inv_from_other  in  1  remote invalidate of snoop_addr
wb_req  out  1  dirty-victim writeback request
wb_addr  out  ADDR_W  victim address {tag,index}
wb_data  out  DATA_W  victim data
wb_ack  in  1  writeback accepted

Behaviour:
- Reset:
  - All line states I; FSM in IDLE.
  - All request, writeback and snoop outputs are 0, cpu_rdata=0, and cpu_stall=0.
- Reset mid-operation aborts any request immediately; it does not wait for a pending grant or fill.
- FSM states: IDLE, WB, REQ, FILL, UPG.
- IDLE, read hit (S/M): cpu_rdata is the line data, combinational; no stall.
- IDLE, write hit on M: line data updated at the next edge; no stall.
- IDLE, write hit on S:
  - Go to UPG; cpu_stall=1.
  - Assert invalidate, with bico=cpu_addr, until grant.
  - On grant: line becomes M, data is written, and the FSM returns to IDLE the next cycle.
- IDLE, miss (tag mismatch or I), cpu_stall=1:
  - If the victim is M, go to WB.
  - Otherwise go to REQ.
- WB: wb_req=1 with wb_addr/wb_data held until wb_ack; then go to REQ. Victim line becomes I on wb_ack.
- REQ:
  - Assert read_miss (load) or write_miss (store), with bico=cpu_addr, held level until grant.
  - Grant seen: go to FILL.
- FILL: wait for fill_valid, then install tag and data:
  - Load: line state S.
  - Store: data is cpu_wdata, line state M.
  - Return to IDLE; cpu_stall drops in the IDLE cycle.
  - Minimum miss latency: 3 cycles from request to unstall with grant and fill back-to-back.
- Only one request line (read_miss/write_miss/invalidate/wb_req) is high at a time.
- Snoop outputs (combinational, from snoop_addr):
  - search_found = search && tag match && state!=I.
  - block_state = matched state, else I.
  - snoop_data = line data.
- Snoop state updates at the next edge:
  - search hit on M: M->S (copy supplied).
  - inv_from_other hit: line ->I.
- Collision rules:
  - Snoop and local updates to different lines apply independently in the same cycle.
  - Same line in UPG with inv_from_other: the snoop wins and the line becomes I. The FSM drops invalidate and moves to REQ as a write miss, with no grant consumed.
  - Same line, FILL completing with inv_from_other the same cycle: the fill wins (remote inval referred to the old copy).
  - A remote invalidate during an own-line write hit on M has no effect (M is exclusive).
- Grant while no request is pending is ignored. fill_valid outside FILL is ignored.

Optional Feature:
- COH_PERF_CNT_EN defined:
  - Adds outputs hit_cnt[15:0], miss_cnt[15:0] and upg_cnt[15:0].
  - Each saturates at 16'hFFFF and resets to 0.
  - hit counts cycles accepting a hit. miss counts entries into REQ. upg counts entries into UPG.
- COH_PERF_CNT_EN not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load 0x0041 -> read_miss=1, bico=0x0041. Grant, then fill 0xBEEF -> rdata=0xBEEF, cpu_stall low, line S; repeat load hits with no stall.
- Store 0x0041=0x1234 on S line -> invalidate until grant. Line M, next load returns 0x1234, and a snoop at 0x0041 gives block_state=2'b10.
- Store 0x0049 (same index, line M) -> wb_req with wb_addr=0x0041, wb_data=0x1234. After wb_ack, write_miss, then fill -> line M holds the store data.
- Snoop search at 0x0049 (M) -> search_found=1, snoop_data correct; the next cycle block_state=2'b01. inv_from_other -> block_state=2'b00.
- Pending UPG on 0x0010 plus inv_from_other for 0x0010 before grant -> invalidate drops, write_miss rises with bico=0x0010, final line M.
- Assert rst_n=0 during FILL -> all outputs 0, all lines I. Next load misses.
